// File: rtl/sim_ctrl_pkg.sv
// Shared definitions for the simulation-control unit.
//   - FSM state encodings (HOLD -> INIT -> RUN -> DONE)
//   - character width
//   - width helpers for channel indices and FIFO pointers
package sim_ctrl_pkg;

  localparam int CHAR_W = 8;

  typedef logic [1:0] sim_state_t;

  localparam logic [1:0] ST_HOLD = 2'd0;  // core held in reset
  localparam logic [1:0] ST_INIT = 2'd1;  // single-cycle host init
  localparam logic [1:0] ST_RUN  = 2'd2;  // stepping, counting cycles
  localparam logic [1:0] ST_DONE = 2'd3;  // terminal until reset

  // Channel index width; a single channel still needs one bit.
  function automatic int chan_w(input int num_chan);
    return (num_chan > 1) ? $clog2(num_chan) : 1;
  endfunction

  // FIFO pointer width: one extra wrap bit to tell full from empty.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sim_char_fifo.sv
// Single-clock show-ahead character FIFO, one per UART channel.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset (empties FIFO)
//   push_i, din_i  write request and character
//   pop_i          read request (must only be raised while !empty_o)
//   dout_o         head character, valid whenever !empty_o
//   full_o/empty_o occupancy flags
//   drop_o         push refused this cycle (full and no simultaneous pop)
module sim_char_fifo
  import sim_ctrl_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [CHAR_W-1:0] din_i,
  input  logic              pop_i,
  output logic [CHAR_W-1:0] dout_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              drop_o
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;

  logic [PW-1:0]     wr_q, rd_q;
  logic [CHAR_W-1:0] mem_q [DEPTH];
  logic              wr_en, rd_en;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[PW-1] != rd_q[PW-1]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

  // A push into a full FIFO is still taken when the head leaves the same
  // cycle: the freed slot is exactly the one being written.
  assign wr_en  = push_i && (!full_o || pop_i);
  assign rd_en  = pop_i && !empty_o;
  assign drop_o = push_i && full_o && !pop_i;

  assign dout_o = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (wr_en) wr_q <= wr_q + PW'(1);
      if (rd_en) rd_q <= rd_q + PW'(1);
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/sim_ctrl_unit.sv
// Simulation-control unit between the testbench shell and SimTop.
// Sequences DUT reset and the host init call, counts run cycles with a
// max-cycle watchdog and log window, and merges NUM_UART character streams
// into one registered print port with round-robin arbitration.
// Ports:
//   clock, reset        system clock, asynchronous active-high reset
//   max_cycles          run-cycle limit (0 = unlimited)
//   log_begin/log_end   log window [begin, end); log_end 0 disables logging
//   finish_req          request to end the run
//   uart_in_valid/_ch   per-channel character strobes and characters
//   out_ready           host print sink ready
//   core_reset          reset to the DUT (high exactly in HOLD)
//   init_pulse/step_en  host init (one cycle) and step enable
//   cycle_cnt           RUN cycles elapsed
//   log_enable          registered log-window flag
//   out_valid/_chan/_ch registered print port
//   overflow            sticky per-channel drop flags
//   timeout/done        run ended by watchdog / run finished
//   dbg_state           current FSM state
//
// Print port handshake: a character moves when out_valid && out_ready at a
// rising clock edge; while out_valid is high and out_ready low, out_valid,
// out_chan and out_ch hold their values.
module sim_ctrl_unit
  import sim_ctrl_pkg::*;
#(
  parameter int NUM_UART     = 4,
  parameter int FIFO_DEPTH   = 16,
  parameter int RESET_CYCLES = 50,
  parameter int CYCLE_W      = 64
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [CYCLE_W-1:0]            max_cycles,
  input  logic [63:0]                   log_begin,
  input  logic [63:0]                   log_end,
  input  logic                          finish_req,
  input  logic [NUM_UART-1:0]           uart_in_valid,
  input  logic [NUM_UART*CHAR_W-1:0]    uart_in_ch,
  input  logic                          out_ready,
  output logic                          core_reset,
  output logic                          init_pulse,
  output logic                          step_en,
  output logic [CYCLE_W-1:0]            cycle_cnt,
  output logic                          log_enable,
  output logic                          out_valid,
  output logic [chan_w(NUM_UART)-1:0]   out_chan,
  output logic [CHAR_W-1:0]             out_ch,
  output logic [NUM_UART-1:0]           overflow,
  output logic                          timeout,
  output logic                          done,
  output sim_state_t                    dbg_state
);

  localparam int CHAN_W = chan_w(NUM_UART);
  localparam int HOLD_W = $clog2(RESET_CYCLES + 1);
  localparam int CMP_W  = (CYCLE_W > 64) ? CYCLE_W : 64;

  // ---------------------------------------------------------------------
  // Run-control FSM
  // ---------------------------------------------------------------------
  sim_state_t         state_q, state_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [CYCLE_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic               timeout_q, timeout_d;
  logic               log_q, log_d;

  assign cnt_inc = cnt_q + CYCLE_W'(1);

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    case (state_q)
      ST_HOLD: begin
        if (hold_q == HOLD_W'(RESET_CYCLES - 1)) state_d = ST_INIT;
        else                                     hold_d  = hold_q + HOLD_W'(1);
      end
      ST_INIT: state_d = ST_RUN;
      ST_RUN: begin
        // The exiting edge still counts, so the frozen value equals the
        // number of RUN cycles spent.
        cnt_d = cnt_inc;
        if (finish_req) state_d = ST_DONE;
        if ((max_cycles != '0) && (cnt_inc == max_cycles)) begin
          state_d   = ST_DONE;
          timeout_d = 1'b1;
        end
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_HOLD;
    endcase
  end

  // Compare in a common width so any CYCLE_W works against 64-bit bounds.
  logic [CMP_W-1:0] cnt_ext, lb_ext, le_ext;
  assign cnt_ext = CMP_W'(cnt_q);
  assign lb_ext  = CMP_W'(log_begin);
  assign le_ext  = CMP_W'(log_end);
  assign log_d   = (log_end != 64'd0) && (cnt_ext >= lb_ext) && (cnt_ext < le_ext);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_HOLD;
      hold_q    <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      log_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      log_q     <= log_d;
    end
  end

  assign core_reset = (state_q == ST_HOLD);
  assign init_pulse = (state_q == ST_INIT);
  assign step_en    = (state_q == ST_RUN);
  assign done       = (state_q == ST_DONE);
  assign cycle_cnt  = cnt_q;
  assign log_enable = log_q;
  assign timeout    = timeout_q;
  assign dbg_state  = state_q;

  // ---------------------------------------------------------------------
  // Per-channel capture FIFOs
  // ---------------------------------------------------------------------
  logic [NUM_UART-1:0] push_w, pop_w, empty_w, full_w, drop_w;
  logic [CHAR_W-1:0]   dout_w [NUM_UART];
  logic [NUM_UART-1:0] ovf_q;

  assign push_w = uart_in_valid & {NUM_UART{!core_reset}};

  for (genvar g = 0; g < NUM_UART; g++) begin : g_fifo
    sim_char_fifo #(
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk_i   (clock),
      .rst_i   (reset),
      .push_i  (push_w[g]),
      .din_i   (uart_in_ch[g*CHAR_W +: CHAR_W]),
      .pop_i   (pop_w[g]),
      .dout_o  (dout_w[g]),
      .full_o  (full_w[g]),
      .empty_o (empty_w[g]),
      .drop_o  (drop_w[g])
    );
  end

  // ---------------------------------------------------------------------
  // Round-robin arbiter and registered print port
  // ---------------------------------------------------------------------
  logic [CHAN_W-1:0] rr_ptr_q;
  logic              out_valid_q;
  logic [CHAN_W-1:0] out_chan_q;
  logic [CHAR_W-1:0] out_ch_q;

  logic              found;
  logic [CHAN_W-1:0] grant_idx, next_ptr;
  logic [CHAR_W-1:0] grant_ch;
  logic              load;
  int                j, jn;

  // The output register takes a new character when empty or being drained.
  assign load = !out_valid_q || out_ready;

  // Search starts at rr_ptr_q (the channel after the last grant) and wraps.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    grant_ch  = '0;
    next_ptr  = rr_ptr_q;
    j         = 0;
    jn        = 0;
    for (int k = 0; k < NUM_UART; k++) begin
      j = int'(rr_ptr_q) + k;
      if (j >= NUM_UART) j = j - NUM_UART;
      if (!found && !empty_w[j]) begin
        found     = 1'b1;
        grant_idx = CHAN_W'(j);
        grant_ch  = dout_w[j];
        jn        = (j + 1 >= NUM_UART) ? 0 : j + 1;
        next_ptr  = CHAN_W'(jn);
      end
    end
  end

  always_comb begin
    pop_w = '0;
    for (int i = 0; i < NUM_UART; i++) begin
      pop_w[i] = load && found && (grant_idx == CHAN_W'(i));
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_chan_q  <= '0;
      out_ch_q    <= '0;
      ovf_q       <= '0;
    end else begin
      ovf_q <= ovf_q | drop_w;
      if (load) begin
        out_valid_q <= found;
        if (found) begin
          out_chan_q <= grant_idx;
          out_ch_q   <= grant_ch;
          rr_ptr_q   <= next_ptr;
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_chan  = out_chan_q;
  assign out_ch    = out_ch_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_sim_ctrl_unit.sv
// Bench for sim_ctrl_unit: run sequencing, watchdog, finish request, log
// window, resets, round-robin print merging and overflow handling.
module tb_sim_ctrl_unit;
  import sim_ctrl_pkg::*;

  localparam int NU = 4;
  localparam int FD = 16;
  localparam int RC = 50;
  localparam int CW = 64;
  localparam int XW = 2;
  localparam int EW = XW + 8;

  logic              clock;
  logic              reset;
  logic [CW-1:0]     max_cycles;
  logic [63:0]       log_begin, log_end;
  logic              finish_req;
  logic [NU-1:0]     uart_in_valid;
  logic [NU*8-1:0]   uart_in_ch;
  logic              out_ready;
  logic              core_reset, init_pulse, step_en, log_enable;
  logic [CW-1:0]     cycle_cnt;
  logic              out_valid;
  logic [XW-1:0]     out_chan;
  logic [7:0]        out_ch;
  logic [NU-1:0]     overflow;
  logic              timeout, done;
  sim_state_t        dbg_state;

  sim_ctrl_unit #(
    .NUM_UART     (NU),
    .FIFO_DEPTH   (FD),
    .RESET_CYCLES (RC),
    .CYCLE_W      (CW)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .max_cycles    (max_cycles),
    .log_begin     (log_begin),
    .log_end       (log_end),
    .finish_req    (finish_req),
    .uart_in_valid (uart_in_valid),
    .uart_in_ch    (uart_in_ch),
    .out_ready     (out_ready),
    .core_reset    (core_reset),
    .init_pulse    (init_pulse),
    .step_en       (step_en),
    .cycle_cnt     (cycle_cnt),
    .log_enable    (log_enable),
    .out_valid     (out_valid),
    .out_chan      (out_chan),
    .out_ch        (out_ch),
    .overflow      (overflow),
    .timeout       (timeout),
    .done          (done),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete in time");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic push_chars(input logic [NU-1:0] mask, input logic [NU*8-1:0] chars);
    uart_in_valid = mask;
    uart_in_ch    = chars;
    tick(1);
    uart_in_valid = '0;
    uart_in_ch    = '0;
  endtask

  task automatic exp_push(input int chan, input logic [7:0] c);
    exp_q.push_back({XW'(chan), c});
  endtask

  task automatic wait_run();
    int n;
    n = 0;
    while (!step_en && n < 200) begin
      tick(1);
      n++;
    end
    check("reach_run", step_en, 1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick(1);
      n++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  task automatic check_reset_values(input string p);
    check({p, ".core_reset"}, core_reset, 1);
    check({p, ".init_pulse"}, init_pulse, 0);
    check({p, ".step_en"},    step_en,    0);
    check({p, ".cycle_cnt"},  cycle_cnt,  0);
    check({p, ".log_enable"}, log_enable, 0);
    check({p, ".timeout"},    timeout,    0);
    check({p, ".done"},       done,       0);
    check({p, ".overflow"},   overflow,   0);
    check({p, ".out_valid"},  out_valid,  0);
    check({p, ".out_chan"},   out_chan,   0);
    check({p, ".out_ch"},     out_ch,     0);
    check({p, ".state"},      dbg_state,  ST_HOLD);
  endtask

  // ---------------- output monitor ----------------
  // Sampled on the falling edge: a transfer seen here completes at the next
  // rising edge.
  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", out_valid, 0);
      end else begin
        check("out_char", {out_chan, out_ch}, exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n, ec, pc;
    bit log_seen, done_seen;
    logic [7:0] c;

    reset         = 1'b1;
    max_cycles    = 64'd10;
    log_begin     = 64'd3;
    log_end       = 64'd6;
    finish_req    = 1'b0;
    uart_in_valid = '0;
    uart_in_ch    = '0;
    out_ready     = 1'b1;

    // Sequencing, log window and watchdog.
    tick(3);
    check_reset_values("rst0");
    reset = 1'b0;
    n = 0;
    while (core_reset && n < 200) begin
      tick(1);
      n++;
    end
    check("hold_cycles", n, RC);
    check("init_pulse_hi", init_pulse, 1);
    check("init_step_lo", step_en, 0);
    check("init_state", dbg_state, ST_INIT);
    tick(1);
    check("init_pulse_lo", init_pulse, 0);
    check("run_step_en", step_en, 1);
    check("run_cnt0", cycle_cnt, 0);
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      ec = (k < 10) ? k : 10;
      pc = (k - 1 < 10) ? k - 1 : 10;
      check($sformatf("wd_cnt_%0d", k), cycle_cnt, ec);
      check($sformatf("wd_log_%0d", k), log_enable, (pc >= 3 && pc < 6) ? 1 : 0);
      check($sformatf("wd_done_%0d", k), done, (k >= 10) ? 1 : 0);
      check($sformatf("wd_timeout_%0d", k), timeout, (k >= 10) ? 1 : 0);
      check($sformatf("wd_step_%0d", k), step_en, (k < 10) ? 1 : 0);
    end
    check("wd_core_reset", core_reset, 0);

    // Asynchronous reset while in DONE.
    reset = 1'b1;
    #1;
    check_reset_values("rst_done");
    tick(2);

    // Unlimited run, logging off, then reset mid-RUN.
    max_cycles = '0;
    log_begin  = 64'd0;
    log_end    = 64'd0;
    reset      = 1'b0;
    wait_run();
    log_seen  = 1'b0;
    done_seen = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      tick(1);
      log_seen  |= log_enable;
      done_seen |= done;
    end
    check("unl_cnt", cycle_cnt, 1000);
    check("unl_done", done_seen, 0);
    check("unl_log", log_seen, 0);
    check("unl_timeout", timeout, 0);
    reset = 1'b1;
    #1;
    check_reset_values("rst_run");
    tick(2);

    // Finish request at cycle_cnt 5; a push during HOLD must be ignored.
    reset = 1'b0;
    tick(1);
    push_chars(4'b0001, 32'h0000_0021);
    wait_run();
    check("hold_push_dropped", out_valid, 0);
    tick(5);
    check("fin_cnt5", cycle_cnt, 5);
    finish_req = 1'b1;
    tick(1);
    finish_req = 1'b0;
    check("fin_done", done, 1);
    check("fin_timeout", timeout, 0);
    check("fin_cnt", cycle_cnt, 6);
    check("fin_step", step_en, 0);
    tick(3);
    check("fin_cnt_frozen", cycle_cnt, 6);
    check("fin_core_reset", core_reset, 0);
    check("fin_out_idle", out_valid, 0);

    // Round robin, latency and throughput (captures still work in DONE).
    exp_push(0, 8'h41);
    exp_push(1, 8'h42);
    exp_push(2, 8'h43);
    exp_push(3, 8'h44);
    push_chars(4'b1111, 32'h4443_4241);
    check("lat_first_cycle", out_valid, 0);
    tick(1);
    check("lat_valid", out_valid, 1);
    check("lat_char", {out_chan, out_ch}, {2'd0, 8'h41});
    tick(3);
    check("thru_last", {out_chan, out_ch}, {2'd3, 8'h44});
    wait_drain();
    tick(1);
    check("rr_idle", out_valid, 0);

    exp_push(0, 8'h7A);
    exp_push(2, 8'h78);
    exp_push(2, 8'h79);
    push_chars(4'b0101, 32'h0078_007A);
    push_chars(4'b0100, 32'h0079_0000);
    wait_drain();

    // Backpressure and overflow on channel 1.
    out_ready = 1'b0;
    exp_push(3, 8'h51);
    push_chars(4'b1000, 32'h5100_0000);
    tick(2);
    check("bp_hold_valid", out_valid, 1);
    check("bp_hold_char", {out_chan, out_ch}, {2'd3, 8'h51});
    for (int i = 0; i < 20; i++) begin
      c = 8'h61 + 8'(i);
      if (i < FD) exp_push(1, c);
      push_chars(4'b0010, {16'h0000, c, 8'h00});
    end
    check("ovf_flag", overflow, 4'b0010);
    check("bp_stable_valid", out_valid, 1);
    check("bp_stable_char", {out_chan, out_ch}, {2'd3, 8'h51});
    // Release and push into the full FIFO on the same edge as its pop.
    exp_push(1, 8'h23);
    out_ready     = 1'b1;
    uart_in_valid = 4'b0010;
    uart_in_ch    = 32'h0000_2300;
    tick(1);
    uart_in_valid = '0;
    uart_in_ch    = '0;
    wait_drain();
    check("ovf_sticky", overflow, 4'b0010);

    // finish_req and watchdog on the same edge.
    reset = 1'b1;
    tick(1);
    check("rst_ovf_clear", overflow, 0);
    max_cycles = 64'd4;
    reset      = 1'b0;
    wait_run();
    tick(3);
    check("both_cnt3", cycle_cnt, 3);
    finish_req = 1'b1;
    tick(1);
    finish_req = 1'b0;
    check("both_done", done, 1);
    check("both_timeout", timeout, 1);
    check("both_cnt", cycle_cnt, 4);

    tick(2);
    check("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sim_ctrl_unit.md
Name: sim_ctrl_unit

Overview:
Synthesizable simulation-control block that sits between the testbench shell and SimTop. It replaces ad-hoc initial/always logic with a parametrised unit that provides:
- reset sequencing and a one-shot init pulse
- a run-cycle counter with max-cycle watchdog and log window
- buffered, round-robin serialisation of N UART output channels toward a single host print port

All of this lets multi-core / multi-UART SoCs share one print sink.

Parameters:
NUM_UART, 4, number of UART output channels captured (1..16)
FIFO_DEPTH, 16, per-channel character FIFO depth, power of 2, >=2
RESET_CYCLES, 50, cycles core_reset is held after reset deasserts (>=1)
CYCLE_W, 64, width of cycle counter and max_cycles

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
max_cycles  in  CYCLE_W  run-cycle limit; 0 = unlimited; sampled every cycle
log_begin  in  64  first cycle of log window (inclusive)
log_end  in  64  end of log window (exclusive); 0 = logging off
finish_req  in  1  host/step checker requests end of run
uart_in_valid  in  NUM_UART  per-channel char strobe from DUT
uart_in_ch  in  NUM_UART*8  per-channel chars, channel i at [8i+7:8i]
out_ready  in  1  host print sink ready
core_reset  out  1  reset to DUT
init_pulse  out  1  one-cycle pulse, host init call
step_en  out  1  host step call enable
cycle_cnt  out  CYCLE_W  RUN cycles elapsed
log_enable  out  1  cycle_cnt inside log window
out_valid  out  1  char available to host
out_chan  out  max(1,$clog2(NUM_UART))  source channel of out_ch
out_ch  out  8  character
overflow  out  NUM_UART  sticky per-channel drop flag
timeout  out  1  sticky, run ended by max_cycles
done  out  1  run finished

Behaviour:
- Reset values (async, on reset high):
  - state=HOLD, core_reset=1, init_pulse=0, step_en=0
  - cycle_cnt=0, log_enable=0, timeout=0, done=0, overflow=0
  - all FIFOs empty; out_valid=0, out_chan=0, out_ch=0
- FSM transitions:
  - HOLD: hold counter counts RESET_CYCLES cycles, then INIT.
  - INIT: lasts exactly 1 cycle; core_reset=0, init_pulse=1. Next state RUN.
  - RUN: step_en=1; cycle_cnt += 1 every cycle.
  - RUN -> DONE when finish_req=1, or when max_cycles!=0 and cycle_cnt+1==max_cycles (timeout set the same edge).
  - finish_req and timeout on the same edge: both done=1 and timeout=1.
  - DONE: terminal until reset; step_en=0, cycle_cnt frozen, done=1, core_reset stays 0.
- core_reset is 1 exactly in HOLD, so the DUT sees RESET_CYCLES+reset-duration cycles of reset.
- Reset asserted mid-RUN or mid-DONE: immediate return to the reset values. Buffered chars are discarded.
- log_enable is registered, = (log_end!=0) && (cycle_cnt>=log_begin) && (cycle_cnt<log_end). It is valid 1 cycle after cycle_cnt.
- Capture:
  - Channel i pushes uart_in_ch[i] when uart_in_valid[i] && !core_reset.
  - Pushes are accepted in HOLD? No: only when core_reset=0, including INIT/RUN/DONE.
  - Push to a full FIFO is dropped and overflow[i] is set (sticky), unless a pop from that FIFO occurs the same cycle. Then the push is accepted.
- Output:
  - out_valid/out_ch/out_chan are registered.
  - A char is transferred when out_valid && out_ready.
  - While out_valid && !out_ready, outputs are stable.
  - Round-robin arbiter picks the next non-empty channel after the last granted one. Priority pointer resets to channel 0, so the first grant goes to the lowest non-empty index >=0.
  - Per-channel order is preserved.
  - Latency: a push into an empty system with out_ready=1 yields out_valid 2 cycles later (FIFO write, then output register load). Sustained throughput is 1 char/cycle.
- FIFO pointers are $clog2(FIFO_DEPTH)+1 bits with natural wrap. Full = MSB differs and low bits equal.

Decomposition:
- sim_ctrl_pkg:
  - state enum {HOLD, INIT, RUN, DONE}
  - CHAN_W and PTR_W localparam functions
  - char width constant 8
- Sub-module sim_char_fifo, instantiated NUM_UART times:
  - single-clock, async reset
  - push/pop/full/empty/dout
  - show-ahead, so dout is valid while !empty

Test Plan:
- Sequencing: reset 3 cycles, RESET_CYCLES=50 -> core_reset low after 50 clocks; init_pulse high exactly 1 cycle; step_en from next cycle; cycle_cnt=0 at first RUN cycle.
- Watchdog: max_cycles=10 -> done=1, timeout=1 after 10 RUN cycles; cycle_cnt frozen at 10. With max_cycles=0 and 1000 cycles, no done.
- finish_req pulsed at cycle_cnt=5 -> done=1, timeout=0, cycle_cnt frozen at 6, step_en=0.
- Round robin: all 4 channels push 'A','B','C','D' together, out_ready=1 -> output order ch0 A, ch1 B, ch2 C, ch3 D. Then ch2 pushes 'x','y' while ch0 pushes 'z' -> interleaved z, x, y per pointer rule.
- Backpressure/overflow: out_ready=0, ch1 pushes 20 chars with FIFO_DEPTH=16 -> overflow[1]=1, only the first 16 chars are later delivered in order. Push on full with a simultaneous pop is accepted.
- Log window: log_begin=3, log_end=6 -> log_enable high for cycle_cnt 3..5 (one cycle registered lag). log_end=0 -> never high. Mid-run reset returns every output to its reset value.
